// File: rtl/formula_inv_if.sv
// Operand/result handshake bundle for the formula inverse solver.
// The master side presents a, b, c, q and takes back d/err.
interface formula_inv_if #(
  parameter int width = 8
);
  logic                      vld_in;
  logic                      rdy_in;
  logic signed [width-1:0]   a;
  logic signed [width-1:0]   b;
  logic signed [width-1:0]   c;
  logic signed [2*width+6:0] q;
  logic                      vld_out;
  logic                      rdy_out;
  logic signed [width-1:0]   d;
  logic                      err;

  modport master (
    output vld_in, a, b, c, q, rdy_out,
    input  rdy_in, vld_out, d, err
  );

  modport slave (
    input  vld_in, a, b, c, q, rdy_out,
    output rdy_in, vld_out, d, err
  );
endinterface

// File: rtl/formula_inv.sv
// Recovers d from q = ((a-b)*(3c+1) - 4d) >>> 1, given a, b, c and q.
// One problem at a time; the product is formed by a serial shift-add multiplier.
module formula_inv #(
  parameter int width = 8
) (
  input logic          clk,
  input logic          rst,
  formula_inv_if.slave bus
);
  localparam int xw = width + 1;
  localparam int yw = width + 3;
  localparam int aw = 2*width + 4;
  localparam int pw = 2*width + 5;
  localparam int qw = 2*width + 7;
  localparam int rw = 2*width + 8;
  localparam int cw = $clog2(yw);

  typedef enum logic [1:0] {IDLE, MUL, FIN, OUT} state_t;

  state_t           state_reg, state_next;
  logic [aw-1:0]    acc_reg, acc_next;
  logic [aw-1:0]    mcand_reg, mcand_next;
  logic [yw-1:0]    mplier_reg, mplier_next;
  logic [cw-1:0]    cnt_reg, cnt_next;
  logic             neg_reg, neg_next;
  logic [qw-1:0]    q_reg, q_next;
  logic [width-1:0] d_reg, d_next;
  logic             err_reg, err_next;

  // Operand preparation, only meaningful at the accepting edge
  logic signed [xw-1:0] x_val;
  logic signed [yw-1:0] c_ext, y_val;
  logic [xw-1:0]        x_mag;
  logic [yw-1:0]        y_mag;

  assign x_val = xw'(bus.a) - xw'(bus.b);
  assign c_ext = yw'(bus.c);
  assign y_val = (c_ext <<< 1) + c_ext + yw'(1);
  assign x_mag = x_val[xw-1] ? -x_val : x_val;
  assign y_mag = y_val[yw-1] ? -y_val : y_val;

  // Undo the floor shift: 2q plus the product's parity bit gives the exact numerator
  logic signed [pw-1:0]   p_val;
  logic signed [rw-1:0]   n_val, r_val, r_sh;
  logic [rw-width:0]      r_hi;
  logic                   in_range;

  assign p_val    = neg_reg ? -$signed({1'b0, acc_reg}) : $signed({1'b0, acc_reg});
  assign n_val    = $signed({q_reg, p_val[0]});
  assign r_val    = rw'(p_val) - n_val;
  assign r_sh     = r_val >>> 2;
  assign r_hi     = r_sh[rw-1:width-1];
  assign in_range = (&r_hi) | ~(|r_hi);

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    cnt_next    = cnt_reg;
    neg_next    = neg_reg;
    q_next      = q_reg;
    d_next      = d_reg;
    err_next    = err_reg;
    case (state_reg)
      IDLE: begin
        if (bus.vld_in) begin
          acc_next    = '0;
          mcand_next  = aw'(x_mag);
          mplier_next = y_mag;
          cnt_next    = '0;
          neg_next    = x_val[xw-1] ^ y_val[yw-1];
          q_next      = bus.q;
          state_next  = MUL;
        end
      end
      MUL: begin
        if (mplier_reg[0]) acc_next = acc_reg + mcand_reg;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        if (cnt_reg == cw'(yw - 1)) state_next = FIN;
      end
      FIN: begin
        err_next   = (|r_val[1:0]) | ~in_range;
        d_next     = err_next ? '0 : r_sh[width-1:0];
        state_next = OUT;
      end
      OUT: begin
        if (bus.rdy_out) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
      q_reg      <= '0;
      d_reg      <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      cnt_reg    <= cnt_next;
      neg_reg    <= neg_next;
      q_reg      <= q_next;
      d_reg      <= d_next;
      err_reg    <= err_next;
    end
  end

  assign bus.rdy_in  = (state_reg == IDLE);
  assign bus.vld_out = (state_reg == OUT);
  assign bus.d       = d_reg;
  assign bus.err     = err_reg;
endmodule

// File: tb/tb_formula_inv.sv
// Directed vectors, a forward-formula random loop and reset/back-to-back
// sequences for formula_inv at width 8.
module tb_formula_inv;
  localparam int W  = 8;
  localparam int QW = 2*W + 7;
  localparam int LAT = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  formula_inv_if #(.width(W)) bus();
  formula_inv #(.width(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int a, b, c, q, d, err, st_out;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full handshake for one problem; garbage replaces the operands right after acceptance.
  task automatic transact(input string tag, input int a, input int b, input int c,
                          input int q, input int exp_d, input int exp_err,
                          input int st_in, input int st_out);
    int waited, lat;
    int busy_ok, hold_ok;
    int d0, e0;
    bus.vld_in = 1'b0;
    repeat (st_in) tick;
    bus.vld_in = 1'b1;
    bus.a = W'(a);
    bus.b = W'(b);
    bus.c = W'(c);
    bus.q = QW'(q);
    waited = 0;
    while (!bus.rdy_in && waited < 50) begin
      tick;
      waited++;
    end
    if (!bus.rdy_in) begin
      chk({tag, " accept"}, int'(bus.rdy_in), 1);
      bus.vld_in = 1'b0;
      return;
    end
    tick;
    bus.vld_in = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.c = W'($urandom);
    bus.q = QW'($urandom);
    busy_ok = 1;
    lat = 0;
    while (!bus.vld_out && lat < 100) begin
      if (bus.rdy_in) busy_ok = 0;
      tick;
      lat++;
    end
    if (bus.rdy_in) busy_ok = 0;
    chk({tag, " vld_out"}, int'(bus.vld_out), 1);
    if (!bus.vld_out) return;
    chk({tag, " latency"}, lat, LAT);
    chk({tag, " rdy_in busy"}, busy_ok, 1);
    chk({tag, " d"}, int'(bus.d), exp_d);
    chk({tag, " err"}, int'(bus.err), exp_err);
    d0 = int'(bus.d);
    e0 = int'(bus.err);
    hold_ok = 1;
    repeat (st_out) begin
      tick;
      if (!bus.vld_out || int'(bus.d) != d0 || int'(bus.err) != e0 || bus.rdy_in) hold_ok = 0;
    end
    if (st_out > 0) chk({tag, " hold"}, hold_ok, 1);
    bus.rdy_out = 1'b1;
    tick;
    bus.rdy_out = 1'b0;
    chk({tag, " vld_out drop"}, int'(bus.vld_out), 0);
    chk({tag, " rdy_in back"}, int'(bus.rdy_in), 1);
    $display("%s: a=%0d b=%0d c=%0d q=%0d -> d=%0d err=%0d lat=%0d",
             tag, a, b, c, q, d0, e0, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ra, rb, rc, rd, rq;
    bus.vld_in  = 1'b0;
    bus.rdy_out = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c = '0;
    bus.q = '0;

    vecs[0]  = '{5, 2, 1, 0, 3, 0, 5};
    vecs[1]  = '{-128, 127, -128, 49088, -128, 0, 0};
    vecs[2]  = '{3, 0, 0, -1, 1, 0, 1};
    vecs[3]  = '{5, 2, 1, 1, 0, 1, 0};
    vecs[4]  = '{5, 2, 1, -300, 0, 1, 2};
    vecs[5]  = '{5, 2, 1, -100, 53, 0, 0};
    vecs[6]  = '{7, 7, 20, -6, 3, 0, 0};
    vecs[7]  = '{10, 4, -3, -14, -5, 0, 3};
    vecs[8]  = '{127, -128, 127, 48451, 127, 0, 0};
    vecs[9]  = '{-3, 0, 0, -2, 0, 0, 0};
    vecs[10] = '{0, 0, 0, -256, 0, 1, 0};
    vecs[11] = '{0, 0, 0, 256, -128, 0, 0};

    #1;
    chk("reset rdy_in", int'(bus.rdy_in), 1);
    chk("reset vld_out", int'(bus.vld_out), 0);
    chk("reset d", int'(bus.d), 0);
    chk("reset err", int'(bus.err), 0);
    tick;
    chk("reset held rdy_in", int'(bus.rdy_in), 1);
    tick;
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      transact($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].q,
               vecs[i].d, vecs[i].err, i % 3, vecs[i].st_out);

    // Reset in the fifth multiply cycle; d still holds -128 from the last vector
    bus.vld_in = 1'b1;
    bus.a = W'(5);
    bus.b = W'(2);
    bus.c = W'(1);
    bus.q = QW'(-100);
    tick;
    bus.vld_in = 1'b0;
    repeat (4) tick;
    chk("pre-rst busy", int'(bus.rdy_in), 0);
    rst = 1'b1;
    #1;
    chk("async rst rdy_in", int'(bus.rdy_in), 1);
    chk("async rst vld_out", int'(bus.vld_out), 0);
    chk("async rst d", int'(bus.d), 0);
    chk("async rst err", int'(bus.err), 0);
    tick;
    chk("rst held rdy_in", int'(bus.rdy_in), 1);
    rst = 1'b0;
    transact("after_rst", 1, 0, 0, -2, 1, 0, 0, 0);

    // Back-to-back with rdy_out and vld_in held high
    bus.rdy_out = 1'b1;
    bus.vld_in  = 1'b1;
    bus.a = W'(5);
    bus.b = W'(2);
    bus.c = W'(1);
    bus.q = QW'(0);
    chk("b2b first ready", int'(bus.rdy_in), 1);
    tick;
    bus.a = W'(-128);
    bus.b = W'(127);
    bus.c = W'(-128);
    bus.q = QW'(49088);
    lat = 0;
    while (!bus.vld_out && lat < 100) begin
      tick;
      lat++;
    end
    chk("b2b first latency", lat, LAT);
    chk("b2b first d", int'(bus.d), 3);
    tick;
    chk("b2b first pulse", int'(bus.vld_out), 0);
    chk("b2b idle gap", int'(bus.rdy_in), 1);
    tick;
    chk("b2b second accepted", int'(bus.rdy_in), 0);
    bus.vld_in = 1'b0;
    lat = 0;
    while (!bus.vld_out && lat < 100) begin
      tick;
      lat++;
    end
    chk("b2b second latency", lat, LAT);
    chk("b2b second d", int'(bus.d), -128);
    chk("b2b second err", int'(bus.err), 0);
    tick;
    chk("b2b second pulse", int'(bus.vld_out), 0);
    bus.rdy_out = 1'b0;
    $display("b2b: two problems completed back to back");

    // Forward formula loop: recovered d must equal the random d that produced q
    for (int i = 0; i < 1000; i++) begin
      ra = int'($urandom_range(0, 255)) - 128;
      rb = int'($urandom_range(0, 255)) - 128;
      rc = int'($urandom_range(0, 255)) - 128;
      rd = int'($urandom_range(0, 255)) - 128;
      rq = ((ra - rb) * (3 * rc + 1) - 4 * rd) >>> 1;
      transact($sformatf("rand%0d", i), ra, rb, rc, rq, rd, 0,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
